// File: rtl/sonic_data_ring_pkg.sv
// Shared constants and sizing helpers for the sonic data ring gearbox.
// Optional feature macro: SONIC_DATA_RING_DROP_CNT_EN (rejected-write counter).
package sonic_data_ring_pkg;

    localparam int DEF_IN_WIDTH   = 64;
    localparam int DEF_RATIO      = 2;
    localparam int DEF_BANK_WIDTH = 32;
    localparam int DEF_DEPTH_LOG2 = 9;

    // Number of wr_ptr bits that select a lane inside an output group.
    function automatic int lane_bits(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 0;
    endfunction

    // Physical banks that make up one input-word lane.
    function automatic int banks_per_lane(input int in_width, input int bank_width);
        return in_width / bank_width;
    endfunction

    // Occupancy counter width, in input words, with room for the full value.
    function automatic int count_width(input int depth_log2, input int ratio);
        return depth_log2 + lane_bits(ratio) + 1;
    endfunction

endpackage

// File: rtl/sonic_dpram_bank.sv
// Simple dual-port RAM bank: one write port, one registered read port.
// Read data is not reset and holds its value while rden_i is low.
module sonic_dpram_bank #(
    parameter int WIDTH = 32,
    parameter int AW    = 9
) (
    input  logic             clock_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rden_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [2**AW];

    // Write port and registered read port share the clock; no read-during-write handling needed.
    always_ff @(posedge clock_i) begin
        if (we_i)
            mem_q[waddr_i] <= wdata_i;
        if (rden_i)
            rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/sonic_data_ring_gearbox.sv
// Width-up ring buffer: IN_WIDTH-bit words in, RATIO*IN_WIDTH-bit groups out.
// Storage is RATIO lanes of IN_WIDTH/BANK_WIDTH banks each; a group is readable
// once all of its lanes have been written.
// Optional feature macro: SONIC_DATA_RING_DROP_CNT_EN adds drop_count_o.
module sonic_data_ring_gearbox
    import sonic_data_ring_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int RATIO      = DEF_RATIO,
    parameter int BANK_WIDTH = DEF_BANK_WIDTH,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          flush_i,
    input  logic [IN_WIDTH-1:0]           wr_data_i,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic                          rd_req_i,
    output logic [RATIO*IN_WIDTH-1:0]     rd_data_o,
    output logic                          rd_dv_o,
    output logic                          empty_o,
    output logic [DEPTH_LOG2:0]           used_words_o,
    output logic [lane_bits(RATIO):0]     partial_o,
    output logic                          overflow_o,
`ifdef SONIC_DATA_RING_DROP_CNT_EN
    output logic [31:0]                   drop_count_o,
`endif
    output logic                          underflow_o
);

    localparam int LB  = lane_bits(RATIO);
    localparam int BPL = banks_per_lane(IN_WIDTH, BANK_WIDTH);
    localparam int CW  = count_width(DEPTH_LOG2, RATIO);
    localparam int PW  = DEPTH_LOG2 + LB;
    localparam logic [CW-1:0] CAP   = CW'(RATIO << DEPTH_LOG2);
    localparam logic [CW-1:0] LMASK = CW'(RATIO - 1);

    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   rd_dv_q, rd_seen_q;
    logic                   ovf_q, unf_q;
    logic                   wr_acc, rd_acc;
    logic [PW-1:0]          lane_sel;
    logic [DEPTH_LOG2-1:0]  waddr;
    logic [RATIO*IN_WIDTH-1:0] bank_rdata;

    // Status is decoded straight from the occupancy counter.
    assign wr_ready_o   = (count_q < CAP);
    assign used_words_o = count_q[CW-1:LB];
    assign partial_o    = (LB+1)'(count_q & LMASK);
    assign empty_o      = (used_words_o == '0);
    assign overflow_o   = ovf_q;
    assign underflow_o  = unf_q;
    assign rd_dv_o      = rd_dv_q;
    // Bank outputs are unreset; present zero until the first real read lands.
    assign rd_data_o    = rd_seen_q ? bank_rdata : '0;

    // Anything arriving in a flush cycle is discarded.
    assign wr_acc   = wr_valid_i & wr_ready_o & ~flush_i;
    assign rd_acc   = rd_req_i & ~empty_o & ~flush_i;
    assign lane_sel = wr_ptr_q & PW'(RATIO - 1);
    assign waddr    = DEPTH_LOG2'(wr_ptr_q >> LB);

    // Next-state for pointers and occupancy; a concurrent read and write net out.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc)
                rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (wr_acc ? CW'(1) : CW'(0)) - (rd_acc ? CW'(RATIO) : CW'(0));
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Read-valid pulse follows an accepted read by one cycle; rd_seen gates the data mux.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rd_dv_q   <= 1'b0;
            rd_seen_q <= 1'b0;
        end else begin
            rd_dv_q   <= rd_acc;
            rd_seen_q <= rd_seen_q | rd_acc;
        end
    end

    // Sticky error flags, cleared only by reset or flush.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (flush_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (wr_valid_i & ~wr_ready_o);
            unf_q <= unf_q | (rd_req_i & empty_o);
        end
    end

`ifdef SONIC_DATA_RING_DROP_CNT_EN
    logic [31:0] drop_q;
    assign drop_count_o = drop_q;

    // Saturating count of writes rejected because the ring was full.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            drop_q <= '0;
        else if (flush_i)
            drop_q <= '0;
        else if (wr_valid_i && !wr_ready_o && (drop_q != 32'hFFFF_FFFF))
            drop_q <= drop_q + 32'd1;
    end
`endif

    // Lane l, bank b holds slice b of every input word whose wr_ptr lands in lane l.
    for (genvar l = 0; l < RATIO; l++) begin : g_lane
        for (genvar b = 0; b < BPL; b++) begin : g_bank
            sonic_dpram_bank #(
                .WIDTH (BANK_WIDTH),
                .AW    (DEPTH_LOG2)
            ) u_bank (
                .clock_i (clock_i),
                .we_i    (wr_acc && (lane_sel == PW'(l))),
                .waddr_i (waddr),
                .wdata_i (wr_data_i[b*BANK_WIDTH +: BANK_WIDTH]),
                .rden_i  (rd_acc),
                .raddr_i (rd_ptr_q),
                .rdata_o (bank_rdata[(l*BPL+b)*BANK_WIDTH +: BANK_WIDTH])
            );
        end
    end

endmodule

// File: tb/tb_sonic_data_ring_gearbox.sv
// Directed bench for sonic_data_ring_gearbox: default build plus a RATIO=4,
// IN_WIDTH=32 instance for the ordering check on a second geometry.
module tb_sonic_data_ring_gearbox;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic         flush, wr_valid, wr_ready, rd_req, rd_dv, empty, overflow, underflow;
    logic [63:0]  wr_data;
    logic [127:0] rd_data;
    logic [9:0]   used_words;
    logic [1:0]   partial;

    sonic_data_ring_gearbox dut (
        .clock_i(clk), .reset_i(rst), .flush_i(flush),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rd_req_i(rd_req), .rd_data_o(rd_data), .rd_dv_o(rd_dv),
        .empty_o(empty), .used_words_o(used_words), .partial_o(partial),
        .overflow_o(overflow), .underflow_o(underflow)
    );

    // RATIO=4, IN_WIDTH=32, small depth so the pointers wrap quickly
    logic         flush2, wr_valid2, wr_ready2, rd_req2, rd_dv2, empty2, overflow2, underflow2;
    logic [31:0]  wr_data2;
    logic [127:0] rd_data2;
    logic [3:0]   used_words2;
    logic [2:0]   partial2;

    sonic_data_ring_gearbox #(.IN_WIDTH(32), .RATIO(4), .BANK_WIDTH(32), .DEPTH_LOG2(3)) dut2 (
        .clock_i(clk), .reset_i(rst), .flush_i(flush2),
        .wr_data_i(wr_data2), .wr_valid_i(wr_valid2), .wr_ready_o(wr_ready2),
        .rd_req_i(rd_req2), .rd_data_o(rd_data2), .rd_dv_o(rd_dv2),
        .empty_o(empty2), .used_words_o(used_words2), .partial_o(partial2),
        .overflow_o(overflow2), .underflow_o(underflow2)
    );

    int vec = 0;
    int err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 1'b0; rd_req = 1'b0; flush = 1'b0;
    endtask

    task automatic do_flush();
        idle(); flush = 1'b1; step(); flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); wr_data = '0;
        flush2 = 1'b0; wr_valid2 = 1'b0; rd_req2 = 1'b0; wr_data2 = '0;
        #12;
        vec++; if (rd_dv !== 1'b0)        begin err++; $display("FAIL reset_rd_dv got %b want 0", rd_dv); end
        vec++; if (rd_data !== '0)        begin err++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        vec++; if (empty !== 1'b1)        begin err++; $display("FAIL reset_empty got %b want 1", empty); end
        vec++; if (wr_ready !== 1'b1)     begin err++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        vec++; if (used_words !== 10'd0)  begin err++; $display("FAIL reset_used got %0d want 0", used_words); end
        vec++; if (partial !== 2'd0)      begin err++; $display("FAIL reset_partial got %0d want 0", partial); end
        vec++; if ({overflow, underflow} !== 2'b00) begin err++; $display("FAIL reset_flags got %b want 00", {overflow, underflow}); end
        @(negedge clk); rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        wr_valid = 1'b1; wr_data = 64'h0000_0000_0000_000A; step();
        vec++; if (empty !== 1'b1 || partial !== 2'd1) begin err++; $display("FAIL basic_first_word empty=%b partial=%0d want 1/1", empty, partial); end
        wr_data = 64'h0000_0000_0000_000B; step();
        vec++; if (empty !== 1'b0 || used_words !== 10'd1) begin err++; $display("FAIL basic_group_ready empty=%b used=%0d want 0/1", empty, used_words); end
        wr_valid = 1'b0; rd_req = 1'b1; step();
        vec++; if (rd_dv !== 1'b1) begin err++; $display("FAIL basic_rd_dv got %b want 1", rd_dv); end
        vec++; if (rd_data !== {64'hB, 64'hA}) begin err++; $display("FAIL basic_rd_data got %h want %h", rd_data, {64'hB, 64'hA}); end
        rd_req = 1'b0; step();
        vec++; if (rd_dv !== 1'b0 || empty !== 1'b1) begin err++; $display("FAIL basic_after dv=%b empty=%b want 0/1", rd_dv, empty); end
        vec++; if (rd_data !== {64'hB, 64'hA}) begin err++; $display("FAIL basic_hold got %h", rd_data); end
    endtask

    task automatic test_partial();
        do_flush();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = 64'h20 + 64'(i); step();
        end
        wr_valid = 1'b0;
        vec++; if (used_words !== 10'd1 || partial !== 2'd1) begin err++; $display("FAIL partial_occ used=%0d partial=%0d want 1/1", used_words, partial); end
        rd_req = 1'b1; step();
        vec++; if (rd_dv !== 1'b1 || rd_data !== {64'h21, 64'h20}) begin err++; $display("FAIL partial_read dv=%b data=%h", rd_dv, rd_data); end
        vec++; if (empty !== 1'b1 || partial !== 2'd1) begin err++; $display("FAIL partial_left empty=%b partial=%0d want 1/1", empty, partial); end
        step();
        vec++; if (underflow !== 1'b1 || rd_dv !== 1'b0) begin err++; $display("FAIL partial_underflow unf=%b dv=%b want 1/0", underflow, rd_dv); end
        rd_req = 1'b0;
    endtask

    task automatic test_flush();
        do_flush();
        rd_req = 1'b1; step(); rd_req = 1'b0;
        vec++; if (underflow !== 1'b1) begin err++; $display("FAIL flush_pre_unf got %b want 1", underflow); end
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = 64'h30 + 64'(i); step();
        end
        vec++; if (used_words !== 10'd2 || partial !== 2'd1) begin err++; $display("FAIL flush_pre_occ used=%0d partial=%0d want 2/1", used_words, partial); end
        wr_valid = 1'b1; rd_req = 1'b1; flush = 1'b1; step();
        idle();
        vec++; if (rd_dv !== 1'b0) begin err++; $display("FAIL flush_dv got %b want 0", rd_dv); end
        vec++; if (used_words !== 10'd0 || partial !== 2'd0 || empty !== 1'b1) begin err++; $display("FAIL flush_count used=%0d partial=%0d empty=%b", used_words, partial, empty); end
        vec++; if (underflow !== 1'b0 || overflow !== 1'b0 || wr_ready !== 1'b1) begin err++; $display("FAIL flush_flags unf=%b ovf=%b rdy=%b", underflow, overflow, wr_ready); end
    endtask

    task automatic test_concurrent();
        do_flush();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = 64'h10 + 64'(i); step();
        end
        wr_data = 64'h14; rd_req = 1'b1; step();
        idle();
        vec++; if (used_words !== 10'd1 || partial !== 2'd1) begin err++; $display("FAIL conc_count used=%0d partial=%0d want 1/1", used_words, partial); end
        vec++; if (rd_dv !== 1'b1 || rd_data !== {64'h11, 64'h10}) begin err++; $display("FAIL conc_data dv=%b data=%h", rd_dv, rd_data); end
    endtask

    task automatic test_fill();
        do_flush();
        for (int i = 0; i < 1024; i++) begin
            wr_valid = 1'b1; wr_data = 64'(i); step();
        end
        vec++; if (wr_ready !== 1'b0 || used_words !== 10'd512) begin err++; $display("FAIL fill_full rdy=%b used=%0d want 0/512", wr_ready, used_words); end
        vec++; if (overflow !== 1'b0) begin err++; $display("FAIL fill_no_ovf got %b want 0", overflow); end
        wr_data = 64'hDEAD; step();
        vec++; if (overflow !== 1'b1 || used_words !== 10'd512) begin err++; $display("FAIL fill_ovf ovf=%b used=%0d want 1/512", overflow, used_words); end
        rd_req = 1'b1; step();
        idle();
        vec++; if (used_words !== 10'd511 || partial !== 2'd0) begin err++; $display("FAIL fill_no_bypass used=%0d partial=%0d want 511/0", used_words, partial); end
        vec++; if (rd_dv !== 1'b1 || rd_data !== {64'd1, 64'd0}) begin err++; $display("FAIL fill_first_group dv=%b data=%h", rd_dv, rd_data); end
        do_flush();
        vec++; if (overflow !== 1'b0) begin err++; $display("FAIL fill_flush_ovf got %b want 0", overflow); end
    endtask

    task automatic test_stream();
        logic [63:0]  q[$];
        logic [127:0] exp;
        int sent = 0, cyc = 0;
        bit acc_r;
        do_flush();
        while ((sent < 2000 || q.size() >= 2) && cyc < 20000) begin
            wr_valid = (sent < 2000) && ($urandom_range(0, 3) != 0);
            rd_req   = ($urandom_range(0, 2) != 0);
            wr_data  = {32'(sent) ^ 32'hA5A5_5A5A, 32'(sent)};
            acc_r    = rd_req && (q.size() >= 2);
            exp      = acc_r ? {q[1], q[0]} : '0;
            if (acc_r) begin void'(q.pop_front()); void'(q.pop_front()); end
            if (wr_valid && q.size() + (acc_r ? 2 : 0) < 1024) begin q.push_back(wr_data); sent++; end
            step(); cyc++;
            vec++;
            if (rd_dv !== acc_r || (acc_r && rd_data !== exp)) begin
                err++; $display("FAIL stream_order cyc=%0d dv=%b data=%h want dv=%b data=%h", cyc, rd_dv, rd_data, acc_r, exp);
            end
        end
        idle();
        vec++; if (cyc >= 20000) begin err++; $display("FAIL stream_timeout sent=%0d", sent); end
        vec++; if (used_words !== 10'd0 || partial !== 2'd0) begin err++; $display("FAIL stream_drain used=%0d partial=%0d want 0/0", used_words, partial); end
    endtask

    task automatic test_ratio4();
        logic [31:0]  q[$];
        logic [127:0] exp;
        int sent = 0, cyc = 0;
        bit acc_r;
        while ((sent < 300 || q.size() >= 4) && cyc < 5000) begin
            wr_valid2 = (sent < 300) && ($urandom_range(0, 3) != 0);
            rd_req2   = ($urandom_range(0, 3) == 0);
            wr_data2  = 32'hC000_0000 + 32'(sent);
            acc_r     = rd_req2 && (q.size() >= 4);
            exp       = acc_r ? {q[3], q[2], q[1], q[0]} : '0;
            if (acc_r) for (int k = 0; k < 4; k++) void'(q.pop_front());
            if (wr_valid2 && q.size() + (acc_r ? 4 : 0) < 32) begin q.push_back(wr_data2); sent++; end
            step(); cyc++;
            vec++;
            if (rd_dv2 !== acc_r || (acc_r && rd_data2 !== exp)) begin
                err++; $display("FAIL r4_order cyc=%0d dv=%b data=%h want dv=%b data=%h", cyc, rd_dv2, rd_data2, acc_r, exp);
            end
        end
        wr_valid2 = 1'b0; rd_req2 = 1'b0;
        vec++; if (cyc >= 5000) begin err++; $display("FAIL r4_timeout sent=%0d", sent); end
        vec++; if (used_words2 !== 4'd0 || partial2 !== 3'd0 || empty2 !== 1'b1) begin err++; $display("FAIL r4_drain used=%0d partial=%0d empty=%b", used_words2, partial2, empty2); end
    endtask

    task automatic test_async_reset();
        do_flush();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = 64'h40 + 64'(i); step();
        end
        wr_valid = 1'b0; rd_req = 1'b1; step();
        vec++; if (rd_dv !== 1'b1) begin err++; $display("FAIL arst_pre_dv got %b want 1", rd_dv); end
        #2 rst = 1'b1;
        #1;
        vec++; if (rd_dv !== 1'b0 || empty !== 1'b1) begin err++; $display("FAIL arst_immediate dv=%b empty=%b want 0/1", rd_dv, empty); end
        vec++; if (used_words !== 10'd0 || rd_data !== '0) begin err++; $display("FAIL arst_state used=%0d data=%h", used_words, rd_data); end
        idle();
        @(negedge clk); rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_flush();
        test_concurrent();
        test_fill();
        test_stream();
        test_ratio4();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
